// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control encodings, FSM states and opcode classification for the multicycle core.
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ERR
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } main_state_t;
  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_CMP_I, CLS_BRANCH, CLS_ILLEGAL
  } op_class_t;
  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_DATA   = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BR     = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  function automatic op_class_t op_class(input logic [3:0] op);
    return op <= 4'd6  ? CLS_ALU_R :
           op <= 4'd8  ? CLS_ALU_I :
           op == 4'd9  ? CLS_LOAD  :
           op == 4'd10 ? CLS_STORE :
           op == 4'd11 ? CLS_CMP_I :
           op <= 4'd13 ? CLS_BRANCH : CLS_ILLEGAL;
  endfunction
endpackage

// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: opcode/memory handshake inputs and datapath control outputs of the main FSM.
interface multicycle_main_fsm_if #(parameter int OP_W = 4);
  logic [OP_W-1:0] op;
  logic mem_ready, mem_req, adr_src, ir_write, pc_write, branch, reg_write, mem_write;
  logic [1:0] alu_src_a, alu_src_b, imm_src, alu_op, result_src;
  logic instr_done, bus_err;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  modport master(
    input op, mem_ready,
    output mem_req, adr_src, ir_write, pc_write, branch, reg_write, mem_write,
    alu_src_a, alu_src_b, imm_src, alu_op, result_src, instr_done, bus_err
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , illegal_op
`endif
  );
  modport slave(
    output op, mem_ready,
    input mem_req, adr_src, ir_write, pc_write, branch, reg_write, mem_write,
    alu_src_a, alu_src_b, imm_src, alu_op, result_src, instr_done, bus_err
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , illegal_op
`endif
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts consecutive not-ready wait cycles; expire flags the MEM_TIMEOUT-th one.
module mem_timeout_cnt #(parameter int MEM_TIMEOUT = 15) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || !run) ? '0 : cnt + 1'b1;
  assign expire = run && cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: Moore main control FSM with memory handshake and timeout watchdog.
// MAIN_FSM_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state and raise illegal_op.
module multicycle_main_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  multicycle_main_fsm_if.master bus
);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  localparam main_state_t ILL_NEXT = S_TRAP;
`else
  localparam main_state_t ILL_NEXT = S_FETCH;
`endif
  main_state_t state, state_next;
  op_class_t cls;
  logic cmp_q, run, expire;
  assign cls = (bus.op >> 4) != '0 ? CLS_ILLEGAL : op_class(bus.op[3:0]);
  assign run = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !bus.mem_ready;
  mem_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk(clk), .reset(reset), .run(run), .expire(expire)
  );
  // CMP_I is remembered at DECODE so EXEC_I never needs to look at op again
  always_ff @(posedge clk) begin
    state <= reset ? S_FETCH : state_next;
    cmp_q <= reset ? 1'b0 : state == S_DECODE ? cls == CLS_CMP_I : cmp_q;
  end
  always_comb begin
    state_next = state;
    if (expire) state_next = S_ERR;
    else
      case (state)
        S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: state_next = cls == CLS_ALU_R ? S_EXEC_R :
                               (cls == CLS_ALU_I || cls == CLS_CMP_I) ? S_EXEC_I :
                               (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEMADR :
                               cls == CLS_BRANCH ? S_BRANCH : ILL_NEXT;
        S_EXEC_R: state_next = S_ALUWB;
        S_EXEC_I: state_next = cmp_q ? S_FETCH : S_ALUWB;
        S_MEMADR: state_next = cls == CLS_LOAD ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
        S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
        default:  state_next = state;
      endcase
  end
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_src_a  = SRCA_REG;
    bus.alu_src_b  = SRCB_REG;
    bus.imm_src    = IMM_DATA;
    bus.alu_op     = ALU_ADD;
    bus.result_src = RES_ALUREG;
    bus.instr_done = 1'b0;
    bus.bus_err    = 1'b0;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    bus.illegal_op = 1'b0;
`endif
    if (!reset)
      case (state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_a = SRCA_PC;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_BR;
        end
        S_EXEC_R: bus.alu_op = ALU_FUNCT;
        S_EXEC_I: begin
          bus.alu_src_b  = SRCB_IMM;
          bus.alu_op     = cmp_q ? ALU_SUB : ALU_FUNCT;
          bus.instr_done = cmp_q;
        end
        S_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEMADR: begin
          bus.alu_src_b = SRCB_IMM;
          bus.imm_src   = IMM_MEM;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_MEM;
          bus.instr_done = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.adr_src    = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_BRANCH: begin
          bus.alu_op     = ALU_SUB;
          bus.result_src = RES_ALU;
          bus.branch     = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_ERR: bus.bus_err = 1'b1;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        S_TRAP: bus.illegal_op = 1'b1;
`endif
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: randomized instruction streams checked cycle by cycle against a per-class control script.
module tb_multicycle_main_fsm;
  localparam int T = 15;
  typedef struct packed {
    logic mem_req, adr_src, ir_write, pc_write, branch, reg_write, mem_write;
    logic [1:0] a, b, imm, aop, rs;
    logic done, err;
  } ctrl_t;
  typedef struct {
    bit rst;
    bit rdy;
    logic [3:0] op;
    ctrl_t e;
    bit ill;
  } step_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  step_t q[$];
  always #5 clk = ~clk;
  multicycle_main_fsm_if #(.OP_W(4)) bus();
  multicycle_main_fsm #(.OP_W(4), .MEM_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic ctrl_t mk(bit mr, bit as, bit irw, bit pcw, bit br, bit rw, bit mw,
                               int a, int b, int imm, int aop, int rs, bit dn);
    return {mr, as, irw, pcw, br, rw, mw, 2'(a), 2'(b), 2'(imm), 2'(aop), 2'(rs), dn, 1'b0};
  endfunction
  function automatic ctrl_t v_fetch(bit r);  return mk(1,0,r,r,0,0,0, 1,2,0,0,0, 0); endfunction
  function automatic ctrl_t v_decode();      return mk(0,0,0,0,0,0,0, 2,1,2,0,0, 0); endfunction
  function automatic ctrl_t v_exec_r();      return mk(0,0,0,0,0,0,0, 0,0,0,2,0, 0); endfunction
  function automatic ctrl_t v_exec_i(bit c); return mk(0,0,0,0,0,0,0, 0,1,0,c ? 1 : 2,0, c); endfunction
  function automatic ctrl_t v_aluwb();       return mk(0,0,0,0,0,1,0, 0,0,0,0,0, 1); endfunction
  function automatic ctrl_t v_memadr();      return mk(0,0,0,0,0,0,0, 0,1,1,0,0, 0); endfunction
  function automatic ctrl_t v_memrd();       return mk(1,1,0,0,0,0,0, 0,0,0,0,0, 0); endfunction
  function automatic ctrl_t v_memwb();       return mk(0,0,0,0,0,1,0, 0,0,0,0,1, 1); endfunction
  function automatic ctrl_t v_memwr(bit r);  return mk(1,1,0,0,0,0,1, 0,0,0,0,0, r); endfunction
  function automatic ctrl_t v_branch();      return mk(0,0,0,0,1,0,0, 0,0,0,1,2, 1); endfunction
  function automatic ctrl_t v_err();         return ctrl_t'(1); endfunction

  function automatic logic [3:0] noise();
    return 4'($urandom());
  endfunction
  task automatic push(bit r, logic [3:0] o, ctrl_t e);
    q.push_back('{rst: 1'b0, rdy: r, op: o, e: e, ill: 1'b0});
  endtask
  task automatic push_rst(int n);
    for (int i = 0; i < n; i++) q.push_back('{rst: 1'b1, rdy: 1'($urandom()), op: noise(), e: '0, ill: 1'b0});
  endtask
  task automatic push_err(int n);
    for (int i = 0; i < n; i++) push(1'($urandom()), noise(), v_err());
  endtask
  // memory wait phase: w not-ready cycles then ready; w >= T never gets ready and ends in ERR
  task automatic push_wait(int w, bit is_wr, bit is_fetch, output bit err);
    int n = w >= T ? T : w;
    for (int i = 0; i < n; i++)
      push(1'b0, noise(), is_fetch ? v_fetch(0) : is_wr ? v_memwr(0) : v_memrd());
    err = w >= T;
    if (!err) push(1'b1, noise(), is_fetch ? v_fetch(1) : is_wr ? v_memwr(1) : v_memrd());
  endtask
  // expected cycle script of one instruction, fw/mw = not-ready cycles in fetch / memory access
  task automatic model_instr(logic [3:0] op, int fw, int mw, output bit err);
    push_wait(fw, 0, 1, err);
    if (err) return;
    push(1'($urandom()), op, v_decode());
    if (op inside {[0:6]}) begin
      push(1'($urandom()), noise(), v_exec_r());
      push(1'($urandom()), noise(), v_aluwb());
    end else if (op inside {[7:8]}) begin
      push(1'($urandom()), noise(), v_exec_i(0));
      push(1'($urandom()), noise(), v_aluwb());
    end else if (op == 11) begin
      push(1'($urandom()), noise(), v_exec_i(1));
    end else if (op inside {[12:13]}) begin
      push(1'($urandom()), noise(), v_branch());
    end else if (op inside {[9:10]}) begin
      push(1'($urandom()), op, v_memadr());
      push_wait(mw, op == 10, 0, err);
      if (!err && op == 9) push(1'($urandom()), noise(), v_memwb());
    end
  endtask
  task automatic play(string name);
    step_t s;
    ctrl_t obs;
    bit obs_ill;
    int cyc = 0;
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = s.rst;
      bus.mem_ready = s.rdy;
      bus.op = s.op;
      #1;
      obs = {bus.mem_req, bus.adr_src, bus.ir_write, bus.pc_write, bus.branch, bus.reg_write,
             bus.mem_write, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_op,
             bus.result_src, bus.instr_done, bus.bus_err};
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      obs_ill = bus.illegal_op;
`else
      obs_ill = 1'b0;
`endif
      n_chk++;
      if ({obs, obs_ill} !== {s.e, s.ill})
        $display("FAIL %s cycle %0d: got ctrl=%h ill=%b, expected ctrl=%h ill=%b",
                 name, cyc, obs, obs_ill, s.e, s.ill);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    push_rst(3);
    play("reset");
  endtask
  task automatic test_alu_r();
    bit e;
    model_instr(4'd0, 0, 0, e);
    model_instr(4'd7, 0, 0, e);
    play("alu");
  endtask
  task automatic test_load();
    bit e;
    model_instr(4'd9, 0, 3, e);
    play("load");
  endtask
  task automatic test_store_branch_cmp();
    bit e;
    model_instr(4'd10, 1, 2, e);
    model_instr(4'd12, 0, 0, e);
    model_instr(4'd11, 0, 0, e);
    play("store_branch_cmp");
  endtask
  task automatic test_timeout_edge();
    bit e;
    model_instr(4'd9, T - 1, T - 1, e);
    model_instr(4'd10, 0, T - 1, e);
    play("timeout_edge");
  endtask
  task automatic test_timeout();
    bit e;
    model_instr(4'd0, T, 0, e);
    push_err(5);
    push_rst(2);
    model_instr(4'd9, 0, T, e);
    push_err(3);
    push_rst(1);
    model_instr(4'd1, 0, 0, e);
    play("timeout");
  endtask
  task automatic test_reset_mid();
    bit e;
    push(1'b1, noise(), v_fetch(1));
    push(1'b0, 4'd9, v_decode());
    push(1'b1, 4'd9, v_memadr());
    push_rst(1);
    model_instr(4'd5, 1, 0, e);
    play("reset_mid");
  endtask
  task automatic test_illegal();
    bit e;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    push(1'b1, noise(), v_fetch(1));
    push(1'b1, 4'd15, v_decode());
    for (int i = 0; i < 4; i++) q.push_back('{rst: 1'b0, rdy: 1'($urandom()), op: noise(), e: '0, ill: 1'b1});
    push_rst(1);
    model_instr(4'd0, 0, 0, e);
`else
    model_instr(4'd15, 0, 0, e);
    model_instr(4'd14, 2, 0, e);
    model_instr(4'd8, 0, 0, e);
`endif
    play("illegal");
  endtask
  task automatic test_back_to_back();
    bit e;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    int op_max = 13;
`else
    int op_max = 15;
`endif
    for (int i = 0; i < 60; i++)
      model_instr(4'($urandom_range(0, op_max)),
                  $urandom_range(0, 9) == 0 ? T - 1 : $urandom_range(0, 2),
                  $urandom_range(0, 9) == 0 ? T - 1 : $urandom_range(0, 3), e);
    play("back_to_back");
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.op = '0;
    test_reset();
    test_alu_r();
    test_load();
    test_store_branch_cmp();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Multicycle successor to the single-cycle main decoder of the core.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Adds a ready/req handshake to the shared instruction/data memory and a memory-timeout watchdog.
- Sits in the control unit between the instruction register and the datapath muxes/enables; the ALU decoder consumes alu_op.

Parameters:
OP_W, 4, opcode width; the opcode is taken from the low OP_W bits of op, the remaining bits must be zero.
MEM_TIMEOUT, 15, max cycles waiting for mem_ready in any memory state before bus error; must be >=1.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high
op  input  OP_W  opcode from instruction register
mem_ready  input  1  memory completed current access this cycle
mem_req  output  1  memory access request
adr_src  output  1  0=PC, 1=ALU result as memory address
ir_write  output  1  load instruction register
pc_write  output  1  unconditional PC update
branch  output  1  conditional PC update (condition evaluated externally)
reg_write  output  1  register file write enable
mem_write  output  1  store enable (qualified by mem_req)
alu_src_a  output  2  00=reg A, 01=PC, 10=old PC
alu_src_b  output  2  00=reg B, 01=immediate, 10=constant 4
imm_src  output  2  00=data imm, 01=mem offset, 10=branch offset
alu_op  output  2  00=add, 01=sub(compare/branch), 10=decode funct
result_src  output  2  00=ALU reg, 01=mem data, 10=ALU direct
instr_done  output  1  one-cycle pulse on last cycle of each instruction
bus_err  output  1  sticky memory-timeout flag

Behaviour:
- Opcode classes: 0000–0110 ALU_R; 0111–1000 ALU_I; 1001 LOAD; 1010 STORE; 1011 CMP_I; 1100–1101 BRANCH; 1110–1111 ILLEGAL.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, ERR (plus TRAP with the optional feature).
- Reset: state=FETCH, timeout counter=0, bus_err=0. All outputs are 0 while reset is high.
- Outputs are a pure function of state, plus mem_ready in FETCH/MEMRD/MEMWR. Outputs not listed for a state are 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=01, alu_src_b=10, alu_op=00.
  - When mem_ready=1 in the same cycle: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=10, alu_src_b=01, imm_src=10 (branch target precompute).
  - Next state by class: ALU_R→EXEC_R; ALU_I or CMP_I→EXEC_I; LOAD/STORE→MEMADR; BRANCH→BRANCH; ILLEGAL→FETCH (NOP).
- EXEC_R: alu_src_a=00, alu_src_b=00, alu_op=10. Next ALUWB.
- EXEC_I: alu_src_a=00, alu_src_b=01, imm_src=00, alu_op=10.
  - CMP_I uses alu_op=01 and goes to FETCH with instr_done=1.
  - Otherwise next ALUWB.
- ALUWB: reg_write=1, result_src=00, instr_done=1. Next FETCH.
- MEMADR: alu_src_a=00, alu_src_b=01, imm_src=01, alu_op=00. LOAD→MEMRD, STORE→MEMWR.
- MEMRD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, result_src=01, instr_done=1. Next FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready; on ready, instr_done=1 and next FETCH.
- BRANCH: alu_src_a=00, alu_src_b=00, alu_op=01, result_src=10, branch=1, instr_done=1. Next FETCH.
- Latency with zero-wait memory: ALU_R/ALU_I 4 cycles; LOAD 5; STORE 4; BRANCH and CMP_I 3.
- Timeout counter:
  - Clears on entry to any waiting state (FETCH/MEMRD/MEMWR).
  - Increments each cycle mem_ready=0 while in a waiting state.
  - If it reaches MEM_TIMEOUT with mem_ready=0, go to ERR.
  - mem_ready=1 on the same cycle the count hits MEM_TIMEOUT wins: normal transition, no error.
- ERR: all enables 0, bus_err=1. Held until reset.
- reset asserted mid-instruction aborts it. The next cycle is FETCH with no writes.
- op is sampled only in DECODE and MEMADR. The instruction register is stable after FETCH.

Optional Feature:
- Macro: MAIN_FSM_ILLEGAL_TRAP_EN.
- Defined: DECODE with an ILLEGAL opcode goes to TRAP instead of FETCH. TRAP holds all enables 0 and drives an extra output illegal_op=1, sticky until reset. The illegal_op port exists only when the macro is defined.
- Undefined: ILLEGAL opcodes behave as a 2-cycle NOP with instr_done=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum main_state_t;
  - 2-bit encodings for alu_src_a/b, imm_src, alu_op, result_src;
  - opcode-class constants;
  - function op_class(op) returning an opcode-class enum.
- One sub-module, mem_timeout_cnt (counter, clear, expire flag), parametrised by MEM_TIMEOUT.

Test Plan:
- op=0000, mem_ready=1 always → states FETCH,DECODE,EXEC_R,ALUWB; reg_write=1 only in cycle 4; instr_done pulse in cycle 4.
- op=1001, mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles; result_src=01 and reg_write=1 in MEMWB; total 8 cycles.
- op=1010 → mem_write=1 with adr_src=1 only in MEMWR; reg_write never 1.
- op=1100 → branch=1 in cycle 3 with alu_op=01; next FETCH in cycle 4.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → ERR after 15 cycles; bus_err=1 until reset; reset mid-ERR → FETCH with bus_err=0.
- op=1111 → NOP back to FETCH with the macro undefined; TRAP with illegal_op=1 sticky with the macro defined.
